alu_exec_unit: RTL

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_core.sv | 27 ++
 rtl/alu_exec_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALU_control codes and the exec-unit state encoding.
// Used by the ALU decoder, alu_core and alu_exec_unit.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Width of the shift amount field and of the shift down-counter
    localparam int SHAMT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational single-cycle ALU datapath: ADD, SUB, AND, OR, SLT (signed).
// Every code it does not recognise, including SLL, falls back to ADD;
// the multi-cycle shift lives in alu_exec_unit.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    // Opcode select; add/sub wrap modulo 2^WIDTH
    always_comb begin
        y = a + b;
        case (alu_control)
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: y = a + b;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: valid/ready request side, held result on the output side.
// Single-cycle ops complete in one cycle with back-to-back throughput.
// Optional feature macro ALU_EXEC_SHIFT_EN: code 100 runs as a bit-serial SLL
// (one bit per cycle, 5-bit down-counter); without it code 100 executes as ADD.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALU_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    alu_state_e         state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               out_valid_q, out_valid_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0]   core_y;
    logic               accept;
    logic               sll_req;
    logic [SHAMT_W-1:0] shamt;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .alu_control (ALU_control),
        .a           (src_a),
        .b           (src_b),
        .y           (core_y)
    );

`ifdef ALU_EXEC_SHIFT_EN
    assign sll_req = (ALU_control == ALU_SLL);
    assign shamt   = src_b[SHAMT_W-1:0];
`else
    assign sll_req = 1'b0;
    assign shamt   = '0;
`endif

    // Ready in IDLE, or in DONE when the held result is being taken this cycle
    assign in_ready  = !rst && ((state_q == ST_IDLE) ||
                                (state_q == ST_DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = (result_q == '0);
    assign busy      = (state_q != ST_IDLE);

    // Next-state logic: retire/accept in IDLE/DONE, shift one bit per cycle in SHIFT
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (state_q == ST_DONE && out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
                if (accept) begin
                    if (sll_req) begin
                        // Shifter works in place on the result register
                        result_d = src_a;
                        if (shamt == '0) begin
                            state_d     = ST_DONE;
                            out_valid_d = 1'b1;
                        end else begin
                            state_d     = ST_SHIFT;
                            out_valid_d = 1'b0;
                            cnt_d       = shamt;
                        end
                    end else begin
                        result_d    = core_y;
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                result_d = result_q << 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == 1) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight operation
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
